// File: rtl/branch_unit.sv
// Branch resolve + optional 2-bit BHT predictor (table built only with `define BRANCH_PREDICT_EN).
// Latency: resolve/prediction combinational; table and counters update on the clock edge.
// Backpressure: none; one execute-stage instruction accepted every cycle.
module branch_unit #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          BHT_ENTRIES  = 64,
  parameter logic [1:0]  COUNTER_INIT = 2'b01
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           fetch_pc_i,
  output logic                  predict_taken_o,
  input  logic                  ex_valid_i,
  input  logic [31:0]           ex_pc_i,
  input  logic [6:0]            opcode_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  input  logic                  ex_pred_taken_i,
  output logic                  pc_src_o,
  output logic                  mispredict_o,
  output logic [31:0]           branch_count_o,
  output logic [31:0]           mispredict_count_o
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic taken;
  logic legal_f3;
  logic is_jump;
  logic br_valid;

  always_comb begin
    taken    = 1'b0;
    legal_f3 = 1'b1;
    case (funct3_i)
      3'b000:  taken = (rs1_data_i == rs2_data_i);
      3'b001:  taken = (rs1_data_i != rs2_data_i);
      3'b100:  taken = ($signed(rs1_data_i) <  $signed(rs2_data_i));
      3'b101:  taken = ($signed(rs1_data_i) >= $signed(rs2_data_i));
      3'b110:  taken = (rs1_data_i <  rs2_data_i);
      3'b111:  taken = (rs1_data_i >= rs2_data_i);
      default: legal_f3 = 1'b0;
    endcase
  end

  assign is_jump      = (opcode_i == OP_JAL) || (opcode_i == OP_JALR);
  assign br_valid     = ex_valid_i && (opcode_i == OP_BRANCH) && legal_f3;
  assign pc_src_o     = (ex_valid_i && is_jump) || (br_valid && taken);
  assign mispredict_o = br_valid && (taken != ex_pred_taken_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count_o     <= '0;
      mispredict_count_o <= '0;
    end else begin
      if (br_valid)     branch_count_o     <= branch_count_o + 32'd1;
      if (mispredict_o) mispredict_count_o <= mispredict_count_o + 32'd1;
    end
  end

`ifdef BRANCH_PREDICT_EN
  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             unused_pc_bits;

  assign fetch_idx       = fetch_pc_i[IDX_W+1:2];
  assign ex_idx          = ex_pc_i[IDX_W+1:2];
  assign unused_pc_bits  = ^{fetch_pc_i[31:IDX_W+2], fetch_pc_i[1:0],
                             ex_pc_i[31:IDX_W+2], ex_pc_i[1:0]};
  // Lookup reads the registered table, so a same-index update shows next cycle.
  assign predict_taken_o = bht[fetch_idx][1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= COUNTER_INIT;
    end else if (br_valid) begin
      if (taken && bht[ex_idx] != 2'b11)
        bht[ex_idx] <= bht[ex_idx] + 2'b01;
      else if (!taken && bht[ex_idx] != 2'b00)
        bht[ex_idx] <= bht[ex_idx] - 2'b01;
    end
  end
`else
  logic unused_pc_bits;

  assign unused_pc_bits  = ^{fetch_pc_i, ex_pc_i};
  assign predict_taken_o = 1'b0;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit; predictor expectations collapse to 0 when the table is not built.
module tb_branch_unit;

`ifdef BRANCH_PREDICT_EN
  localparam logic PE = 1'b1;
`else
  localparam logic PE = 1'b0;
`endif

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc_i;
  logic        predict_taken_o;
  logic        ex_valid_i;
  logic [31:0] ex_pc_i;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        ex_pred_taken_i;
  logic        pc_src_o;
  logic        mispredict_o;
  logic [31:0] branch_count_o;
  logic [31:0] mispredict_count_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_unit dut (
    .clk                (clk),
    .rst                (rst),
    .fetch_pc_i         (fetch_pc_i),
    .predict_taken_o    (predict_taken_o),
    .ex_valid_i         (ex_valid_i),
    .ex_pc_i            (ex_pc_i),
    .opcode_i           (opcode_i),
    .funct3_i           (funct3_i),
    .rs1_data_i         (rs1_data_i),
    .rs2_data_i         (rs2_data_i),
    .ex_pred_taken_i    (ex_pred_taken_i),
    .pc_src_o           (pc_src_o),
    .mispredict_o       (mispredict_o),
    .branch_count_o     (branch_count_o),
    .mispredict_count_o (mispredict_count_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [6:0] op,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic p);
    ex_valid_i      = v;
    ex_pc_i         = pc;
    opcode_i        = op;
    funct3_i        = f3;
    rs1_data_i      = a;
    rs2_data_i      = b;
    ex_pred_taken_i = p;
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic exp_pre [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    logic tk;
    rst        = 1'b1;
    fetch_pc_i = 32'h0;
    drive(1'b0, 32'h0, 7'h0, 3'b000, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_brcnt", branch_count_o, 32'd0);
    chk("rst_mpcnt", mispredict_count_o, 32'd0);
    chk("rst_pred_0", predict_taken_o, 1'b0);
    fetch_pc_i = 32'hFC; #1;
    chk("rst_pred_fc", predict_taken_o, 1'b0);
    chk("idle_pcsrc", pc_src_o, 1'b0);

    // BEQ taken, predicted not-taken
    tick();
    fetch_pc_i = 32'h40;
    drive(1'b1, 32'h40, OP_BR, 3'b000, 32'd5, 32'd5, 1'b0); #1;
    chk("beq_pcsrc", pc_src_o, 1'b1);
    chk("beq_misp", mispredict_o, 1'b1);
    chk("beq_pred_old", predict_taken_o, 1'b0);
    tick();
    drive(1'b0, 32'h0, 7'h0, 3'b000, 32'h0, 32'h0, 1'b0); #1;
    chk("beq_pred_new", predict_taken_o, PE);
    chk("beq_brcnt", branch_count_o, 32'd1);
    chk("beq_mpcnt", mispredict_count_o, 32'd1);

    // Signed vs unsigned compares
    drive(1'b1, 32'h204, OP_BR, 3'b100, 32'hFFFF_FFFF, 32'd1, 1'b1); #1;
    chk("blt_pcsrc", pc_src_o, 1'b1);
    chk("blt_misp", mispredict_o, 1'b0);
    tick();
    drive(1'b1, 32'h208, OP_BR, 3'b110, 32'hFFFF_FFFF, 32'd1, 1'b1); #1;
    chk("bltu_pcsrc", pc_src_o, 1'b0);
    chk("bltu_misp", mispredict_o, 1'b1);
    tick();
    drive(1'b1, 32'h20C, OP_BR, 3'b101, 32'd7, 32'd7, 1'b1); #1;
    chk("bge_pcsrc", pc_src_o, 1'b1);
    chk("bge_misp", mispredict_o, 1'b0);
    tick();
    drive(1'b1, 32'h210, OP_BR, 3'b111, 32'd7, 32'd7, 1'b1); #1;
    chk("bgeu_pcsrc", pc_src_o, 1'b1);
    tick();
    drive(1'b1, 32'h214, OP_BR, 3'b001, 32'd5, 32'd5, 1'b0); #1;
    chk("bne_pcsrc", pc_src_o, 1'b0);
    chk("bne_misp", mispredict_o, 1'b0);
    tick();
    drive(1'b0, 32'h0, 7'h0, 3'b000, 32'h0, 32'h0, 1'b0); #1;
    chk("cmp_brcnt", branch_count_o, 32'd6);
    chk("cmp_mpcnt", mispredict_count_o, 32'd2);

    // Illegal funct3 and invalid branch: no effect anywhere
    fetch_pc_i = 32'h80;
    drive(1'b1, 32'h80, OP_BR, 3'b010, 32'd3, 32'd3, 1'b1); #1;
    chk("ill_pcsrc", pc_src_o, 1'b0);
    chk("ill_misp", mispredict_o, 1'b0);
    tick();
    drive(1'b0, 32'h80, OP_BR, 3'b000, 32'd3, 32'd3, 1'b0); #1;
    chk("inv_pcsrc", pc_src_o, 1'b0);
    chk("inv_misp", mispredict_o, 1'b0);
    tick();
    drive(1'b0, 32'h0, 7'h0, 3'b000, 32'h0, 32'h0, 1'b0); #1;
    chk("ill_brcnt", branch_count_o, 32'd6);
    chk("ill_mpcnt", mispredict_count_o, 32'd2);
    chk("ill_pred", predict_taken_o, 1'b0);

    // Saturation at pc 0x80: 4 taken, 5 not-taken, 2 taken (pre-update predictions)
    for (int i = 0; i < 11; i++) begin
      tk = (i < 4) || (i >= 9);
      drive(1'b1, 32'h80, OP_BR, 3'b000, 32'd1, tk ? 32'd1 : 32'd2, 1'b1); #1;
      chk($sformatf("sat_pred%0d", i), predict_taken_o, PE & exp_pre[i]);
      chk($sformatf("sat_misp%0d", i), mispredict_o, !tk);
      tick();
    end
    drive(1'b0, 32'h0, 7'h0, 3'b000, 32'h0, 32'h0, 1'b0); #1;
    chk("sat_pred_end", predict_taken_o, PE);
    chk("sat_brcnt", branch_count_o, 32'd17);
    chk("sat_mpcnt", mispredict_count_o, 32'd7);

    // Jumps redirect but never train or count
    fetch_pc_i = 32'h300;
    drive(1'b1, 32'h300, OP_JALR, 3'b000, 32'd9, 32'd9, 1'b0); #1;
    chk("jalr_pcsrc", pc_src_o, 1'b1);
    chk("jalr_misp", mispredict_o, 1'b0);
    tick();
    drive(1'b1, 32'h300, OP_JAL, 3'b000, 32'd9, 32'd9, 1'b0); #1;
    chk("jal_pcsrc", pc_src_o, 1'b1);
    chk("jal_misp", mispredict_o, 1'b0);
    tick();
    drive(1'b0, 32'h0, 7'h0, 3'b000, 32'h0, 32'h0, 1'b0); #1;
    chk("jmp_pred", predict_taken_o, 1'b0);
    chk("jmp_brcnt", branch_count_o, 32'd17);
    chk("jmp_mpcnt", mispredict_count_o, 32'd7);

    // Same-index lookup and update
    fetch_pc_i = 32'h100;
    drive(1'b1, 32'h100, OP_BR, 3'b000, 32'd4, 32'd4, 1'b0); #1;
    chk("byp_pred_old", predict_taken_o, 1'b0);
    tick();
    drive(1'b0, 32'h0, 7'h0, 3'b000, 32'h0, 32'h0, 1'b0); #1;
    chk("byp_pred_new", predict_taken_o, PE);
    chk("byp_brcnt", branch_count_o, 32'd18);
    chk("byp_mpcnt", mispredict_count_o, 32'd8);

    // Reset wins over a concurrent mispredicting branch
    rst = 1'b1;
    fetch_pc_i = 32'h40;
    drive(1'b1, 32'h40, OP_BR, 3'b000, 32'd5, 32'd5, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 7'h0, 3'b000, 32'h0, 32'h0, 1'b0); #1;
    chk("rst2_brcnt", branch_count_o, 32'd0);
    chk("rst2_mpcnt", mispredict_count_o, 32'd0);
    chk("rst2_pred_40", predict_taken_o, 1'b0);
    fetch_pc_i = 32'h80; #1;
    chk("rst2_pred_80", predict_taken_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning operand width compared by branches.
REQ-002 The block SHALL have parameter BHT_ENTRIES, default 64, meaning number of 2-bit predictor counters; power of two, 2..1024.
REQ-003 The block SHALL have parameter COUNTER_INIT, default 2'b01, meaning the counter value loaded at reset.
REQ-004 The block SHALL have port clk  input  1  rising-edge clock; one clock, synchronous active-high reset.
REQ-005 The block SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 The block SHALL have port fetch_pc_i  input  32  fetch-stage PC to predict.
REQ-007 The block SHALL have port predict_taken_o  output  1  fetch-stage prediction.
REQ-008 The block SHALL have port ex_valid_i  input  1  execute-stage instruction valid.
REQ-009 The block SHALL have port ex_pc_i  input  32  execute-stage instruction PC.
REQ-010 The block SHALL have port opcode_i  input  7  execute-stage opcode.
REQ-011 The block SHALL have port funct3_i  input  3  execute-stage funct3.
REQ-012 The block SHALL have port rs1_data_i  input  DATA_WIDTH  first compare operand.
REQ-013 The block SHALL have port rs2_data_i  input  DATA_WIDTH  second compare operand.
REQ-014 The block SHALL have port ex_pred_taken_i  input  1  prediction made for this instruction at fetch.
REQ-015 The block SHALL have port pc_src_o  output  1  resolved redirect/taken.
REQ-016 The block SHALL have port mispredict_o  output  1  B-type outcome differs from prediction; flush request.
REQ-017 The block SHALL have port branch_count_o  output  32  resolved B-type count.
REQ-018 The block SHALL have port mispredict_count_o  output  32  mispredict count.

Function
REQ-019 The block SHALL compute taken for opcode 1100011 as: 000 rs1==rs2; 001 rs1!=rs2; 100 signed rs1<rs2; 101 signed rs1>=rs2; 110 unsigned rs1<rs2; 111 unsigned rs1>=rs2; 010/011 not taken and treated as not-a-branch.
REQ-020 The block SHALL drive pc_src_o combinationally: 1 for valid JAL (1101111) or JALR (1100111); taken for valid legal B-type; 0 otherwise or when ex_valid_i=0.
REQ-021 The block SHALL drive mispredict_o combinationally = ex_valid_i & legal B-type & (taken != ex_pred_taken_i); 0 for jumps and non-branches.
REQ-022 The block SHALL index the table with PC[$clog2(BHT_ENTRIES)+1:2], fetch_pc_i for lookup and ex_pc_i for update.
REQ-023 The block SHALL give predict_taken_o = bit 1 of the indexed counter, combinational from the registered table (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
REQ-024 The block SHALL, at the clock edge of a valid legal B-type, increment the counter if taken, decrement if not taken, saturating at 11 and 00.
REQ-025 The block SHALL read the pre-update counter when lookup and update hit the same index in one cycle; the new value is visible the next cycle.
REQ-026 The block SHALL leave the table unchanged for jumps, illegal funct3, non-branches and ex_valid_i=0.
REQ-027 The block SHALL increment branch_count_o per valid legal B-type and mispredict_count_o per mispredict_o=1 cycle, both wrapping 0xFFFFFFFF->0.

Reset
REQ-028 The block SHALL, while rst=1 at a clock edge, load every counter with COUNTER_INIT and clear both count outputs to 0, discarding any concurrent update or increment.
REQ-029 The block SHALL, out of reset with default COUNTER_INIT, output predict_taken_o=0 for every PC.

Configuration
REQ-030 The block SHALL implement the table only when BRANCH_PREDICT_EN is defined, giving the behaviour in REQ-022..REQ-026.
REQ-031 The block SHALL, when BRANCH_PREDICT_EN is undefined, contain no table, tie predict_taken_o=0 (static not-taken), and keep REQ-019..REQ-021 and REQ-027 unchanged.

Verification
REQ-032 The bench SHALL cover: reset, then BEQ rs1=5 rs2=5 pc=0x40 pred=0 -> pc_src_o=1, mispredict_o=1; next cycle counter[16]=10, predict_taken_o=1 for fetch_pc 0x40.
REQ-033 The bench SHALL cover: BLT rs1=0xFFFFFFFF rs2=1 -> taken; BLTU same operands -> not taken; BGE/BGEU with rs1=rs2=7 -> taken.
REQ-034 The bench SHALL cover: four taken branches at pc 0x80 -> counter 11; five not-taken -> 00, never wrapping.
REQ-035 The bench SHALL cover: JALR with ex_pred_taken_i=0 -> pc_src_o=1, mispredict_o=0, counters and table unchanged.
REQ-036 The bench SHALL cover: fetch_pc_i=ex_pc_i=0x100 with taken update -> predict_taken_o shows old value that cycle, new value next cycle.
REQ-037 The bench SHALL cover: rst asserted in the same cycle as a valid mispredicting branch -> counts stay 0, counter at COUNTER_INIT.
